// File: rtl/plb_bank_buffer_if.sv
// plb_bank_buffer_if: host bus and per-channel port bundle for plb_bank_buffer.
interface plb_bank_buffer_if #(
  parameter int NUM_CH     = 4,
  parameter int PLB_DW     = 64,
  parameter int CH_DW      = 8,
  parameter int BANK_WORDS = 2048
);
  localparam int LANES = PLB_DW / CH_DW;
  localparam int PAW   = $clog2(NUM_CH) + $clog2(BANK_WORDS);
  localparam int CAW   = $clog2(BANK_WORDS * LANES);
  logic [PAW-1:0]          plb_addr;
  logic [PLB_DW-1:0]       plb_wdata;
  logic [LANES-1:0]        plb_be;
  logic                    plb_wr;
  logic                    plb_rd;
  logic [PLB_DW-1:0]       plb_rdata;
  logic                    plb_rvalid;
  logic [NUM_CH-1:0]       plb_go;
  logic [NUM_CH-1:0]       plb_ack;
  logic [NUM_CH*CAW-1:0]   ch_addr;
  logic [NUM_CH*CH_DW-1:0] ch_wdata;
  logic [NUM_CH-1:0]       ch_wr;
  logic [NUM_CH-1:0]       ch_rd;
  logic [NUM_CH-1:0]       ch_done;
  logic [NUM_CH*CH_DW-1:0] ch_rdata;
  logic [NUM_CH-1:0]       ch_rvalid;
  logic [2*NUM_CH-1:0]     bank_state;
  logic [15:0]             err_cnt;
  modport master (
    output plb_addr, plb_wdata, plb_be, plb_wr, plb_rd, plb_go, plb_ack,
           ch_addr, ch_wdata, ch_wr, ch_rd, ch_done,
    input  plb_rdata, plb_rvalid, ch_rdata, ch_rvalid, bank_state, err_cnt
  );
  modport slave (
    input  plb_addr, plb_wdata, plb_be, plb_wr, plb_rd, plb_go, plb_ack,
           ch_addr, ch_wdata, ch_wr, ch_rd, ch_done,
    output plb_rdata, plb_rvalid, ch_rdata, ch_rvalid, bank_state, err_cnt
  );
endinterface

// File: rtl/plb_bank_buffer.sv
// plb_bank_buffer: per-channel banked buffer with host/channel ownership handoff.
module plb_bank_buffer #(
  parameter int NUM_CH     = 4,
  parameter int PLB_DW     = 64,
  parameter int CH_DW      = 8,
  parameter int BANK_WORDS = 2048
) (
  input logic clk,
  input logic rst,
  plb_bank_buffer_if.slave bus
);
  localparam int LANES = PLB_DW / CH_DW;
  localparam int AWB   = $clog2(BANK_WORDS);
  localparam int PAW   = $clog2(NUM_CH) + AWB;
  localparam int CAW   = $clog2(BANK_WORDS * LANES);
  localparam int LW    = $clog2(LANES);
  typedef enum logic [1:0] {HOST = 2'b00, CHAN = 2'b01, DONE = 2'b10} st_e;
  st_e st_q [NUM_CH];
  st_e st_d [NUM_CH];
  logic [15:0] err_q, err_d;
  logic [16:0] sum;
  logic [4:0] drops;
  logic [PAW-1:0] hb;
  logic [AWB-1:0] hwa;
  logic [NUM_CH-1:0] hsel, hsel_q, own_h, own_c, crv_q;
  logic h_ok, prv_q;
  logic [NUM_CH*LANES-1:0] clm, csel_q;
  logic [NUM_CH*PLB_DW-1:0] hrd_w;
  logic [NUM_CH*LANES*CH_DW-1:0] crd_w;
  logic [PLB_DW-1:0] phold_q, prd, hmux;
  logic [NUM_CH*CH_DW-1:0] chold_q, crd;
  logic [CH_DW-1:0] cm;
  assign hb = bus.plb_addr >> AWB;
  assign hwa = bus.plb_addr[AWB-1:0];
  assign h_ok = |(hsel & own_h);
  for (genvar b = 0; b < NUM_CH; b++) begin : g_bank
    logic [CAW-1:0] ca;
    logic [AWB-1:0] cwa;
    assign ca = bus.ch_addr[b*CAW +: CAW];
    assign cwa = AWB'(ca >> LW);
    assign hsel[b] = hb == PAW'(b);
    assign own_h[b] = st_q[b] == HOST;
    assign own_c[b] = st_q[b] == CHAN;
    assign bus.bank_state[2*b +: 2] = st_q[b];
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [CH_DW-1:0] mem [BANK_WORDS];
      logic [CH_DW-1:0] hq, cq;
      logic lhit, hwe, cwe;
      assign lhit = (ca & CAW'(LANES-1)) == CAW'(l);
      assign hwe = !rst && bus.plb_wr && hsel[b] && own_h[b] && bus.plb_be[l];
      assign cwe = !rst && bus.ch_wr[b] && own_c[b] && lhit;
      assign clm[b*LANES+l] = !rst && bus.ch_rd[b] && own_c[b] && lhit;
      // read-first on both ports: reads see the pre-write word
      always_ff @(posedge clk) begin
        if (hwe) mem[hwa] <= bus.plb_wdata[PLB_DW-1-l*CH_DW -: CH_DW];
        if (cwe) mem[cwa] <= bus.ch_wdata[b*CH_DW +: CH_DW];
        if (!rst && bus.plb_rd && hsel[b]) hq <= mem[hwa];
        if (clm[b*LANES+l]) cq <= mem[cwa];
      end
      assign hrd_w[b*PLB_DW + PLB_DW-1-l*CH_DW -: CH_DW] = hq;
      assign crd_w[(b*LANES+l)*CH_DW +: CH_DW] = cq;
    end
  end
  always_comb begin
    drops = 5'(bus.plb_wr && !h_ok);
    hmux = '0;
    crd = '0;
    cm = '0;
    for (int b = 0; b < NUM_CH; b++) begin
      st_d[b] = (own_h[b] && bus.plb_go[b]) ? CHAN :
                (own_c[b] && bus.ch_done[b]) ? DONE :
                (st_q[b] == DONE && bus.plb_ack[b]) ? HOST : st_q[b];
      drops = drops + 5'(bus.ch_wr[b] && !own_c[b]) + 5'(bus.ch_rd[b] && !own_c[b]);
      hmux = hmux | (hsel_q[b] ? hrd_w[b*PLB_DW +: PLB_DW] : '0);
      cm = '0;
      for (int l = 0; l < LANES; l++)
        cm = cm | (csel_q[b*LANES+l] ? crd_w[(b*LANES+l)*CH_DW +: CH_DW] : '0);
      crd[b*CH_DW +: CH_DW] = (crv_q[b] && !rst) ? cm : chold_q[b*CH_DW +: CH_DW];
    end
    sum = 17'(err_q) + 17'(drops);
    err_d = sum[16] ? 16'hFFFF : sum[15:0];
    prd = (prv_q && !rst) ? hmux : phold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_CH; b++) st_q[b] <= HOST;
      err_q <= '0;
      prv_q <= 1'b0;
      crv_q <= '0;
      phold_q <= '0;
      chold_q <= '0;
      hsel_q <= '0;
      csel_q <= '0;
    end else begin
      st_q <= st_d;
      err_q <= err_d;
      prv_q <= bus.plb_rd;
      crv_q <= bus.ch_rd;
      phold_q <= prd;
      chold_q <= crd;
      hsel_q <= hsel & {NUM_CH{bus.plb_rd}};
      csel_q <= clm;
    end
  end
  // a read landing in a reset cycle is suppressed so it never shows as valid
  assign bus.plb_rvalid = prv_q && !rst;
  assign bus.plb_rdata = prd;
  assign bus.ch_rvalid = crv_q & ~{NUM_CH{rst}};
  assign bus.ch_rdata = crd;
  assign bus.err_cnt = err_q;
endmodule

// File: doc/plb_bank_buffer.md
PLB_BANK_BUFFER -- requirements
Module: plb_bank_buffer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of channels and banks (1..8).
REQ-002 SHALL have parameter PLB_DW, default 64, meaning host data width; it is a multiple of CH_DW.
REQ-003 SHALL have parameter CH_DW, default 8, meaning channel data width; LANES = PLB_DW/CH_DW.
REQ-004 SHALL have parameter BANK_WORDS, default 2048, meaning host words per bank (power of 2).
REQ-005 SHALL use one clock and a synchronous, active-high reset; all ports below are sampled on the rising edge of clk.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 plb_addr  in  clog2(NUM_CH)+clog2(BANK_WORDS)  host word address; upper bits = bank.
REQ-009 plb_wdata  in  PLB_DW  host write data; lane 0 = most significant CH_DW bits.
REQ-010 plb_be  in  LANES  byte-lane write enables; bit 0 = lane 0.
REQ-011 plb_wr / plb_rd  in  1 each  host write / read strobe.
REQ-012 plb_rdata  out  PLB_DW  host read data; plb_rvalid  out  1  read-data valid.
REQ-013 plb_go / plb_ack  in  NUM_CH each  per-bank hand-to-channel / release pulses.
REQ-014 ch_addr  in  NUM_CH*clog2(BANK_WORDS*LANES)  per-channel lane address; low clog2(LANES) bits = lane.
REQ-015 ch_wdata  in  NUM_CH*CH_DW; ch_wr, ch_rd, ch_done  in  NUM_CH each.
REQ-016 ch_rdata  out  NUM_CH*CH_DW; ch_rvalid  out  NUM_CH.
REQ-017 bank_state  out  2*NUM_CH  per-bank ownership; err_cnt  out  16  dropped-access count.

Function
REQ-018 Channel i SHALL own bank i exclusively; the host SHALL address any bank via plb_addr.
REQ-019 Each bank SHALL have an ownership FSM: HOST(00), CHAN(01), DONE(10); code 11 unused.
REQ-020 Transitions: HOST --plb_go[i]--> CHAN; CHAN --ch_done[i]--> DONE; DONE --plb_ack[i]--> HOST; all other pulses ignored.
REQ-021 Host writes SHALL update only lanes with plb_be set, only when the target bank is in HOST.
REQ-022 Channel writes SHALL update one lane, only when the channel's bank is in CHAN.
REQ-023 Host reads SHALL be permitted in any state; channel reads SHALL be permitted only in CHAN.
REQ-024 Read latency SHALL be 1 cycle: plb_rvalid/ch_rvalid[i] high exactly the cycle after an accepted rd, with data valid in that cycle.
REQ-025 Rejected channel reads SHALL still pulse ch_rvalid with ch_rdata = 0.
REQ-026 Each dropped write or rejected read SHALL increment err_cnt by 1; err_cnt SHALL saturate at 0xFFFF; simultaneous drops on k ports SHALL add k, saturating.
REQ-027 plb_wr and plb_rd together SHALL perform the write and return the old (read-first) data.
REQ-028 A write and a read of the same lane in the same cycle from different ports SHALL be impossible by ownership; a same-port write+read SHALL return old data.
REQ-029 rdata SHALL hold its last value while rvalid is low.
REQ-030 Storage SHALL be inferable as true dual-port block RAM, one per bank per lane.

Reset
REQ-031 rst SHALL force every bank_state to HOST, err_cnt to 0, plb_rvalid and ch_rvalid to 0, plb_rdata and ch_rdata to 0.
REQ-032 rst SHALL NOT clear memory contents; reads in flight during rst SHALL be discarded (no rvalid the cycle after).
REQ-033 Strobes coinciding with rst SHALL have no effect.

Verification
REQ-034 Host writes 0x0011223344556677, be=0xFF, bank 2 word 5; plb_go[2]; ch 2 reads lane addr 40..47 -> ch_rvalid next cycle each, data 0x00,0x11,..,0x77.
REQ-035 Bank 1 in CHAN; ch 1 writes 0xAB at lane addr 3; ch_done[1]; host reads bank 1 word 0 -> rdata bits lane 3 = 0xAB, bank_state[1]=DONE; plb_ack[1] -> HOST.
REQ-036 Host write with be=0x81 to word 0 of bank 0 (HOST) -> only lanes 0 and 7 change; read returns them, others unchanged.
REQ-037 Host writes to bank 3 in CHAN, ch 0 writes while bank 0 in HOST, ch 0 reads in HOST -> memory unchanged, ch_rdata 0 with ch_rvalid, err_cnt = 3.
REQ-038 err_cnt preloaded to 0xFFFE via drops, then two simultaneous drops -> err_cnt = 0xFFFF, holds.
REQ-039 rst asserted one cycle after plb_rd and with banks in CHAN/DONE -> no plb_rvalid, all bank_state 00, err_cnt 0, earlier written data still readable.
